// File: rtl/div_pkg.sv
// Shared definitions for the 8-bit restoring divider: state encoding,
// datapath width, iteration count and the divide-by-zero quotient.
package div_pkg;

  localparam int WIDTH = 8;
  localparam int ITER  = 8;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Debug view of the controller.
  // req_mode is the mode bit sampled at start, whether or not signed division is built in.
  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] count;
    logic             req_mode;
  } dbg_t;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return '0 - v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring trial-subtract/shift iteration. The dividend shift register
// feeds its MSB into the partial remainder and collects quotient bits at its LSB.
module div_step
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0]   w_trial;
  logic [WIDTH+1:0] w_diff;
  logic             w_keep;

  assign w_trial = {i_rem, i_q[WIDTH-1]};
  assign w_diff  = {1'b0, w_trial} - {2'b00, i_divisor};

  // A kept difference is below the divisor, so both top bits are zero.
  assign w_keep  = (w_diff[WIDTH+1:WIDTH] == 2'b00);

  assign o_rem   = w_keep ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_q     = {i_q[WIDTH-2:0], w_keep};

endmodule

// File: rtl/bit_8_divider.sv
// 8-bit multi-cycle restoring divider (IDLE -> CALC x8 -> DONE).
// Define SIGNED_DIV_EN to enable two's-complement division when mode=1.
module bit_8_divider
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Data0,
  input  logic [WIDTH-1:0] Data1,
  input  logic             mode,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow,
  output dbg_t             dbg
);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [CNT_W-1:0] r_count;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_ovf;
  logic             r_mode;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_ovf;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_q;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

`ifdef SIGNED_DIV_EN
  assign w_signed = mode;
`else
  assign w_signed = 1'b0;
`endif

  assign w_a_neg = w_signed & Data0[WIDTH-1];
  assign w_b_neg = w_signed & Data1[WIDTH-1];
  assign w_a_mag = w_a_neg ? twos_neg(Data0) : Data0;
  assign w_b_mag = w_b_neg ? twos_neg(Data1) : Data1;

  // -128 / -1 runs as 128 / 1; the unsigned quotient 8'h80 is already the saturated answer.
  assign w_ovf   = w_signed & (Data0 == 8'h80) & (Data1 == 8'hFF);

  div_step u_step (
    .i_rem     (r_rem),
    .i_q       (r_q),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_q       (w_step_q)
  );

  assign w_q_final = r_neg_q ? twos_neg(w_step_q)   : w_step_q;
  assign w_r_final = r_neg_r ? twos_neg(w_step_rem) : w_step_rem;

  assign dbg = '{state: r_state, count: r_count, req_mode: r_mode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_rem       <= '0;
      r_divisor   <= '0;
      r_count     <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_ovf       <= 1'b0;
      r_mode      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            r_q         <= w_a_mag;
            r_rem       <= '0;
            r_divisor   <= w_b_mag;
            r_count     <= '0;
            r_neg_q     <= w_a_neg ^ w_b_neg;
            r_neg_r     <= w_a_neg;
            r_ovf       <= w_ovf;
            r_mode      <= mode;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (Data1 == '0) begin
              r_state     <= DONE;
              done        <= 1'b1;
              quotient    <= DIV0_QUOTIENT;
              remainder   <= Data0;
              div_by_zero <= 1'b1;
            end else begin
              r_state <= CALC;
              busy    <= 1'b1;
            end
          end
        end
        CALC: begin
          r_q     <= w_step_q;
          r_rem   <= w_step_rem;
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(ITER - 1)) begin
            r_state   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= w_q_final;
            remainder <= w_r_final;
            overflow  <= r_ovf;
          end
        end
        DONE: begin
          r_state <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_8_divider.sv
// Directed-vector bench for bit_8_divider: driver tasks push expected results
// (values and done cycle) into a queue that a negedge monitor pops and checks.
module tb_bit_8_divider;
  import div_pkg::*;

  localparam int W = 35;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] Data0;
  logic [WIDTH-1:0] Data1;
  logic             mode;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;
  dbg_t             dbg;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_k = 0;

  bit_8_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .Data0       (Data0),
    .Data1       (Data1),
    .mode        (mode),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .dbg         (dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Caller is positioned just after an edge; start is sampled on the next edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic m,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edz, input logic eov);
    start  = 1'b1;
    Data0  = a;
    Data1  = b;
    mode   = m;
    last_k = cyc + 1;
    exp_q.push_back({1'b0, eov, edz, eq, er, 16'(last_k + ((b == 8'd0) ? 0 : ITER))});
    @(posedge clk);
    #1;
    start = 1'b0;
    Data0 = 8'($urandom_range(0, 255));
    Data1 = 8'($urandom_range(0, 255));
    mode  = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_ignored(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    Data0 = a;
    Data1 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_quotient"},  32'(quotient),    32'd0);
    check({tag, "_remainder"}, 32'(remainder),   32'd0);
    check({tag, "_busy"},      32'(busy),        32'd0);
    check({tag, "_done"},      32'(done),        32'd0);
    check({tag, "_dz"},        32'(div_by_zero), 32'd0);
    check({tag, "_ovf"},       32'(overflow),    32'd0);
    check({tag, "_state"},     32'(dbg.state),   32'(IDLE));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    if (rst_n && done) begin
      act = {busy, overflow, div_by_zero, quotient, remainder, 16'(cyc)};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got %0h with no result expected", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL result: got {busy,ovf,dz,q,r,cyc}=%0h expected %0h", act, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    Data0 = '0;
    Data1 = '0;
    mode  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    // start presented as reset releases: accepted on the first edge
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0);
    pulse_ignored(8'd3, 8'd1);
    pulse_ignored(8'd200, 8'd9);
    at_cycle(last_k + 8);
    pulse_ignored(8'd50, 8'd5);
    at_cycle(last_k + 12);
    check("held_quotient",  32'(quotient),  32'd14);
    check("held_remainder", 32'(remainder), 32'd2);
    check("held_done",      32'(done),      32'd0);
    drain();

    // back-to-back: second start in the IDLE cycle right after done
    issue(8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0, 1'b0);
    at_cycle(last_k + 9);
    issue(8'd200, 8'd255, 1'b0, 8'd0, 8'd200, 1'b0, 1'b0);
    at_cycle(last_k + 9);
    issue(8'd5, 8'd0, 1'b0, 8'hFF, 8'd5, 1'b1, 1'b0);
    at_cycle(last_k + 1);
    issue(8'd0, 8'd5, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    at_cycle(last_k + 9);
    issue(8'd250, 8'd16, 1'b0, 8'd15, 8'd10, 1'b0, 1'b0);
    at_cycle(last_k + 9);
    issue(8'd17, 8'd17, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0);
    at_cycle(last_k + 9);
    issue(8'd1, 8'd255, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0);
    drain();

`ifdef SIGNED_DIV_EN
    issue(8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0);
    at_cycle(last_k + 9);
    issue(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1);
    at_cycle(last_k + 9);
    issue(8'h64, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0, 1'b0);
    at_cycle(last_k + 9);
    issue(8'hF9, 8'h00, 1'b1, 8'hFF, 8'hF9, 1'b1, 1'b0);
    at_cycle(last_k + 1);
    issue(8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0);
`else
    issue(8'h9C, 8'h07, 1'b1, 8'd22, 8'd2, 1'b0, 1'b0);
    at_cycle(last_k + 9);
    issue(8'h80, 8'hFF, 1'b1, 8'h00, 8'h80, 1'b0, 1'b0);
`endif
    drain();

    // reset in the middle of CALC abandons the operation
    issue(8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0);
    at_cycle(last_k + 4);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_8_divider.md
BIT_8_DIVIDER -- requirements
Module: bit_8_divider

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock), rst_n input 1 (asynchronous active-low reset).
REQ-002 SHALL have start  input  1  request to begin a division; sampled only in IDLE.
REQ-003 SHALL have Data0  input  8  dividend, captured on an accepted start.
REQ-004 SHALL have Data1  input  8  divisor, captured on an accepted start.
REQ-005 SHALL have mode  input  1  1 = signed, 0 = unsigned; meaningful only with SIGNED_DIV_EN.
REQ-006 SHALL have quotient  output  8  result quotient, held until the next accepted start.
REQ-007 SHALL have remainder  output  8  result remainder, held until the next accepted start.
REQ-008 SHALL have busy  output  1  high while a division is in progress (CALC state).
REQ-009 SHALL have done  output  1  one-cycle pulse; results valid in that cycle and after.
REQ-010 SHALL have div_by_zero  output  1  set with done when the captured divisor is 0; held with the results.
REQ-011 SHALL have overflow  output  1  set with done on a signed -128 / -1; held with the results.

Function
REQ-012 SHALL implement the states IDLE, CALC and DONE as a state machine.
REQ-013 SHALL, in IDLE with start=1 at edge k, capture Data0, Data1 and mode, clear the flags, and enter CALC; or enter DONE when the divisor is 0.
REQ-014 SHALL perform one restoring trial-subtract iteration per CALC cycle (9-bit partial remainder minus divisor; on non-negative result keep the difference and shift in 1, else shift in 0), MSB first, for exactly 8 cycles, k+1..k+8.
REQ-015 SHALL enter DONE at edge k+8 and assert done for exactly one cycle (k+9), with busy low, then return to IDLE.
REQ-016 SHALL, for a divisor of 0, skip CALC: done is asserted in cycle k+1, quotient=8'hFF, remainder=captured dividend, div_by_zero=1.
REQ-017 SHALL ignore start in CALC and DONE, with no effect on the operation in progress.
REQ-018 SHALL accept start in the IDLE cycle immediately after DONE, giving back-to-back throughput of one result per 10 cycles.
REQ-019 SHALL, in unsigned mode, satisfy Data0 = quotient*Data1 + remainder, with remainder < Data1.
REQ-020 SHALL keep the Data0 and Data1 inputs don't-care after capture.

Reset
REQ-021 SHALL, on rst_n low (including mid-operation), immediately force IDLE and drive quotient=0, remainder=0, busy=0, done=0, div_by_zero=0 and overflow=0, abandoning any partial result.
REQ-022 SHALL, on rst_n deassertion, accept a start on the first rising clk edge.

Configuration
REQ-023 SHALL support the macro SIGNED_DIV_EN.
REQ-024 SHALL, when SIGNED_DIV_EN is defined and mode=1, divide magnitudes (two's-complement negate at capture), negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-025 SHALL, when SIGNED_DIV_EN is defined and mode=1, produce quotient=8'h80, remainder=0 and overflow=1 for -128 / -1.
REQ-026 SHALL, when SIGNED_DIV_EN is undefined, ignore mode, perform unsigned division only, and tie overflow to 0.

Structure
REQ-027 SHALL take from the shared package div_pkg: the state encoding (IDLE, CALC, DONE), WIDTH=8, ITER=8, and DIV0_QUOTIENT=8'hFF.
REQ-028 SHALL place a single trial-subtract/shift iteration in the combinational sub-module div_step, instantiated once and reused each CALC cycle.

Verification
REQ-029 SHALL cover: unsigned 100/7 with start at cycle 0 -> done in cycle 9, quotient=14, remainder=2, flags=0.
REQ-030 SHALL cover: 255/1, followed by a start in the cycle after done with 200/255 -> results 255/0, then 0/200.
REQ-031 SHALL cover: 5/0 -> done in cycle 1, quotient=8'hFF, remainder=5, div_by_zero=1.
REQ-032 SHALL cover: start pulses with new operands during CALC -> ignored, with the original result unchanged.
REQ-033 SHALL cover: rst_n low at cycle 4 of CALC -> all outputs 0 and IDLE; a following 9/3 gives 3/0.
REQ-034 SHALL cover, with SIGNED_DIV_EN and mode=1: -100/7 -> quotient=8'hF2, remainder=8'hFE; and -128/-1 -> quotient=8'h80, overflow=1.
